// File: rtl/bc_fir_pkg.sv
// Shared types and sizes for the binary FIR tap line.
// `BC_FIR_N sets the sample width; it defaults to 12 when the build does not provide it.
`ifndef BC_FIR_N
`define BC_FIR_N 12
`endif

package bc_fir_pkg;
    localparam int N_TAPS = 19;
    localparam int W      = `BC_FIR_N;
    localparam int CNT_W  = $clog2(N_TAPS + 1);

    typedef logic [W-1:0]         sample_t;
    typedef sample_t [N_TAPS-1:0] tap_arr_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/bc_fir_tap_line.sv
// 19-deep sample window feeding the binary FIR core, with a one-cycle strobe per complete window.
// Define BC_FIR_DRAIN_EN to build the flush/drain path (DRAIN state and drain counter).
module bc_fir_tap_line
    import bc_fir_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_clear,
    input  sample_t  i_in_data,
    input  logic     i_in_valid,
    output logic     o_in_ready,
    input  logic     i_flush,
    output tap_arr_t o_taps,
    output logic     o_taps_valid,
    output cnt_t     o_fill_cnt,
    output state_t   o_state
);

    tap_arr_t r_taps;
    cnt_t     r_fill_cnt;
    logic     r_taps_valid;
    state_t   r_state;
    state_t   w_state_nxt;
    logic     w_accept;
    logic     w_completes;

`ifdef BC_FIR_DRAIN_EN
    cnt_t     r_drain_cnt;
    logic     w_drain_last;
    logic     w_start_drain;

    assign o_in_ready    = !i_rst && !i_clear && (r_state != DRAIN);
    assign w_drain_last  = (r_state == DRAIN) && (r_drain_cnt == cnt_t'(1));
    assign w_start_drain = (r_state == FULL) && i_flush;
`else
    logic     w_flush_unused;

    assign o_in_ready     = !i_rst && !i_clear;
    assign w_flush_unused = i_flush;
`endif

    assign w_accept    = i_in_valid && o_in_ready;
    // Any accept from 18 or 19 held samples leaves a full window behind it.
    assign w_completes = w_accept && (r_fill_cnt >= cnt_t'(N_TAPS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_taps <= '0;
        end else if (i_clear) begin
            r_taps <= '0;
        end else if (w_accept) begin
            r_taps <= {r_taps[N_TAPS-2:0], i_in_data};
`ifdef BC_FIR_DRAIN_EN
        end else if (r_state == DRAIN) begin
            r_taps <= {r_taps[N_TAPS-2:0], sample_t'(0)};
        end else if (r_state == EMPTY) begin
            // Wipes the last drained sample so an idle empty window reads all zero.
            r_taps <= '0;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FILL;
            FILL:    if (w_completes) w_state_nxt = FULL;
`ifdef BC_FIR_DRAIN_EN
            FULL:    if (w_start_drain) w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_last) w_state_nxt = EMPTY;
`endif
            default: w_state_nxt = r_state;
        endcase
        if (i_clear) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fill_cnt   <= '0;
            r_taps_valid <= 1'b0;
        end else if (i_clear) begin
            r_fill_cnt   <= '0;
            r_taps_valid <= 1'b0;
        end else begin
`ifdef BC_FIR_DRAIN_EN
            r_taps_valid <= w_completes || (r_state == DRAIN);
            if (w_drain_last) begin
                r_fill_cnt <= '0;
            end else if (w_accept && (r_fill_cnt != cnt_t'(N_TAPS))) begin
                r_fill_cnt <= r_fill_cnt + cnt_t'(1);
            end
`else
            r_taps_valid <= w_completes;
            if (w_accept && (r_fill_cnt != cnt_t'(N_TAPS))) begin
                r_fill_cnt <= r_fill_cnt + cnt_t'(1);
            end
`endif
        end
    end

`ifdef BC_FIR_DRAIN_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drain_cnt <= '0;
        end else if (i_clear) begin
            r_drain_cnt <= '0;
        end else if (w_start_drain) begin
            r_drain_cnt <= cnt_t'(N_TAPS - 1);
        end else if (r_state == DRAIN) begin
            r_drain_cnt <= r_drain_cnt - cnt_t'(1);
        end
    end
`endif

    assign o_taps       = r_taps;
    assign o_taps_valid = r_taps_valid;
    assign o_fill_cnt   = r_fill_cnt;
    assign o_state      = r_state;

endmodule
